// File: rtl/m_pwm_pkg.sv
// m_pwm_pkg: shared types and helpers for the PWM bank.
//   mode_e   : counter mode encoding (MODE_EDGE=0, MODE_CENTER=1)
//   dir_e    : counter direction for center-aligned mode
//   sat_step : saturating +1/-1 on an unsigned value of a given width (up to 32 bits)
package m_pwm_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // inc&dec together, or neither, leave the value unchanged.
  function automatic logic [31:0] sat_step(input logic [31:0] value,
                                           input logic        inc,
                                           input logic        dec,
                                           input int unsigned width);
    logic [31:0] max_val;
    max_val  = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    sat_step = value;
    if (inc && !dec && (value < max_val)) begin
      sat_step = value + 32'd1;
    end else if (dec && !inc && (value != '0)) begin
      sat_step = value - 32'd1;
    end
  endfunction

endpackage

// File: rtl/m_pwm_timebase.sv
// m_pwm_timebase: shared prescaler and period counter for the PWM bank.
//   clk, rst_n : clock, asynchronous active-low reset
//   presc      : one counter tick every presc+1 clks
//   mode       : requested mode, adopted only at a period boundary
//   cnt        : period counter (edge: 0..2^W-1 wrap; center: up/down triangle)
//   boundary   : tick while cnt==0 (one clk wide)
module m_pwm_timebase
  import m_pwm_pkg::*;
#(
  parameter int W  = 8,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] presc,
  input  logic          mode,
  output logic [W-1:0]  cnt,
  output logic          boundary
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [PW-1:0] pcnt;
  logic          tick;
  dir_e          dir;
  mode_e         mode_q;
  mode_e         mode_eff;

  // >= rather than == so that lowering presc below the running pcnt
  // ticks at once instead of waiting for pcnt to wrap.
  assign tick     = rst_n && (pcnt >= presc);
  assign boundary = tick && (cnt == '0);
  // The tick that opens a period already runs in the newly sampled mode.
  assign mode_eff = boundary ? mode_e'(mode) : mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      dir    <= DIR_UP;
      mode_q <= MODE_EDGE;
    end else if (tick) begin
      if (boundary) begin
        mode_q <= mode_e'(mode);
      end
      if (mode_eff == MODE_EDGE) begin
        cnt <= cnt + 1'b1;
        dir <= DIR_UP;
      end else if ((dir == DIR_UP) || boundary) begin
        cnt <= cnt + 1'b1;
        dir <= (cnt == CNT_MAX - 1'b1) ? DIR_DOWN : DIR_UP;
      end else begin
        cnt <= cnt - 1'b1;
        dir <= (cnt == W'(1)) ? DIR_UP : DIR_DOWN;
      end
    end
  end

endmodule

// File: rtl/m_pwm_bank.sv
// m_pwm_bank: CH-channel PWM generator sharing one timebase.
//   clk, rst_n   : clock, asynchronous active-low reset
//   presc        : prescale value (tick every presc+1 clks)
//   mode         : 0 edge-aligned, 1 center-aligned (applied at period boundary)
//   wr_en/wr_ch/wr_duty : write a channel's pending duty (wr_ch>=CH ignored)
//   up, down     : per-channel saturating pending-duty increment/decrement
//   pwm          : registered PWM outputs
//   duty_out     : active duties, channel i at [i*W +: W]
//   period_start : one-clk pulse at each period boundary
module m_pwm_bank
  import m_pwm_pkg::*;
#(
  parameter int  CH = 4,
  parameter int  W  = 8,
  parameter int  PW = 16,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PW-1:0]   presc,
  input  logic            mode,
  input  logic            wr_en,
  input  logic [CW-1:0]   wr_ch,
  input  logic [W-1:0]    wr_duty,
  input  logic [CH-1:0]   up,
  input  logic [CH-1:0]   down,
  output logic [CH-1:0]   pwm,
  output logic [CH*W-1:0] duty_out,
  output logic            period_start
);

  localparam logic [W-1:0] DUTY_MAX = '1;

  logic [W-1:0] cnt;
  logic         boundary;

  m_pwm_timebase #(
    .W  (W),
    .PW (PW)
  ) u_timebase (
    .clk      (clk),
    .rst_n    (rst_n),
    .presc    (presc),
    .mode     (mode),
    .cnt      (cnt),
    .boundary (boundary)
  );

  assign period_start = boundary;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0] pend;
    logic [W-1:0] pend_nxt;
    logic [W-1:0] act;
    logic         pwm_q;

    always_comb begin
      pend_nxt = W'(sat_step(32'(pend), up[i], down[i], W));
      if (wr_en && (32'(wr_ch) == i)) begin
        pend_nxt = wr_duty;
      end
    end

    // act samples the pre-write pend on a shared write/boundary clk.
    // act==0 falls out of cnt<act; full scale is forced high so the
    // cnt==2^W-1 slot does not drop the output.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend  <= '0;
        act   <= '0;
        pwm_q <= 1'b0;
      end else begin
        pend <= pend_nxt;
        if (boundary) begin
          act <= pend;
        end
        pwm_q <= (act == DUTY_MAX) ? 1'b1 : (cnt < act);
      end
    end

    assign pwm[i]              = pwm_q;
    assign duty_out[i*W +: W]  = act;
  end

endmodule

// File: tb/tb_m_pwm_bank.sv
// tb_m_pwm_bank: scoreboard bench for m_pwm_bank (CH=4, W=8, PW=16).
// Stimulus pushes hand-computed per-period expectations; a monitor measures
// each period (length, high clks per channel, last complete ch0 pulse,
// duty_out) and pops/compares on every period_start.
module tb_m_pwm_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] presc;
  logic        mode;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [7:0]  wr_duty;
  logic [3:0]  up;
  logic [3:0]  down;
  logic [3:0]  pwm;
  logic [31:0] duty_out;
  logic        period_start;

  m_pwm_bank #(
    .CH (4),
    .W  (8),
    .PW (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .presc        (presc),
    .mode         (mode),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_duty      (wr_duty),
    .up           (up),
    .down         (down),
    .pwm          (pwm),
    .duty_out     (duty_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          period;
    int          hi0;
    int          hi1;
    int          hi2;
    int          hi3;
    logic [31:0] duty;
    int          run0;   // -1: not checked
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input longint act_v, input longint exp_v);
    n_vec++;
    if (act_v != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act_v, act_v, exp_v, exp_v);
    end
  endtask

  function automatic exp_t mk(input string name, input int period, input int h0, input int h1,
                              input int h2, input int h3, input logic [31:0] duty, input int run0);
    exp_t e;
    e.name = name; e.period = period;
    e.hi0 = h0; e.hi1 = h1; e.hi2 = h2; e.hi3 = h3;
    e.duty = duty; e.run0 = run0;
    return e;
  endfunction

  // ---------------- monitor ----------------
  int win_len;
  int hc0, hc1, hc2, hc3;
  int run0, last_run0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_len = 0; hc0 = 0; hc1 = 0; hc2 = 0; hc3 = 0;
      run0 = 0; last_run0 = -1;
    end else begin
      if (period_start) begin
        if (sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk({e.name, " period"}, win_len, e.period);
          chk({e.name, " hi ch0"}, hc0, e.hi0);
          chk({e.name, " hi ch1"}, hc1, e.hi1);
          chk({e.name, " hi ch2"}, hc2, e.hi2);
          chk({e.name, " hi ch3"}, hc3, e.hi3);
          chk({e.name, " duty_out"}, duty_out, e.duty);
          if (e.run0 >= 0) chk({e.name, " ch0 pulse"}, last_run0, e.run0);
        end
        win_len = 0; hc0 = 0; hc1 = 0; hc2 = 0; hc3 = 0;
      end
      win_len++;
      hc0 += int'(pwm[0]); hc1 += int'(pwm[1]); hc2 += int'(pwm[2]); hc3 += int'(pwm[3]);
      if (pwm[0]) run0++;
      else if (run0 > 0) begin last_run0 = run0; run0 = 0; end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_ps();
    int n = 0;
    do begin step(); n++; end while (!period_start && n < 5000);
    if (!period_start) chk("period_start timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() > 0 && n < 8000) begin step(); n++; end
    if (sbq.size() > 0) begin
      chk("scoreboard drain timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic write(input logic [1:0] ch, input logic [7:0] val);
    wr_en = 1'b1; wr_ch = ch; wr_duty = val;
    step();
    wr_en = 1'b0;
  endtask

  // Let the new act load at one boundary, then check the next periods.
  task automatic settle(input exp_t e, input int nrec);
    wait_ps();
    wait_ps();
    @(negedge clk); #1;
    for (int k = 0; k < nrec; k++) sbq.push_back(e);
    wait_drain();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n = 1'b0; presc = '0; mode = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_duty = '0; up = '0; down = '0;
    #3;
    chk("reset pwm", pwm, 0);
    chk("reset duty_out", duty_out, 0);
    chk("reset period_start", period_start, 0);
    repeat (3) step();
    rst_n = 1'b1;

    // edge mode, presc=0
    write(2'd0, 8'd64); write(2'd1, 8'd255); write(2'd2, 8'd0); write(2'd3, 8'd128);
    settle(mk("edge p0", 256, 64, 256, 0, 128, 32'h8000FF40, 64), 2);

    // presc=3: tick every 4 clks
    presc = 16'd3;
    settle(mk("edge p3", 1024, 256, 1024, 0, 512, 32'h8000FF40, 256), 2);

    // center mode, ch0=10
    presc = 16'd0; mode = 1'b1;
    write(2'd0, 8'd10);
    settle(mk("center", 510, 19, 510, 0, 255, 32'h8000FF0A, 19), 2);

    // pending duty: saturation, up&down hold, write beats up
    write(2'd1, 8'd0);
    up = 4'b0010; down = 4'b1000;
    repeat (300) step();
    up = 4'b0010; down = 4'b0010;
    repeat (5) step();
    up = 4'b0001; down = 4'b0000;
    repeat (3) step();
    up = 4'b0001; down = 4'b0001;
    repeat (4) step();
    up = 4'b0100; down = 4'b0000;
    write(2'd2, 8'd77);
    up = '0; down = '0;
    settle(mk("pend sat", 510, 25, 510, 153, 0, 32'h004DFF0D, 25), 1);

    // mid-period write: current period keeps the old duty
    wait_ps();
    @(negedge clk); #1;
    sbq.push_back(mk("midwrite old", 510, 25, 510, 153, 0, 32'h004DFF0D, 25));
    repeat (100) step();
    write(2'd0, 8'd200);
    chk("midwrite duty_out ch0", duty_out[7:0], 13);
    wait_drain();
    settle(mk("midwrite new", 510, 399, 510, 153, 0, 32'h004DFFC8, 399), 1);

    // mid-period mode change: period finishes in center mode
    wait_ps();
    @(negedge clk); #1;
    sbq.push_back(mk("mode hold", 510, 399, 510, 153, 0, 32'h004DFFC8, 399));
    repeat (100) step();
    mode = 1'b0;
    wait_drain();
    settle(mk("mode edge", 256, 200, 256, 77, 0, 32'h004DFFC8, 200), 1);

    // asynchronous reset mid-period
    #2;
    chk("pre-reset pwm1", pwm[1], 1);
    rst_n = 1'b0;
    #1;
    chk("async reset pwm", pwm, 0);
    chk("async reset duty_out", duty_out, 0);
    chk("async reset period_start", period_start, 0);
    presc = 16'd3;
    repeat (3) step();
    chk("held reset pwm", pwm, 0);
    rst_n = 1'b1;
    n = 0;
    while (!period_start && n < 20) begin step(); n++; end
    chk("first boundary after release", n, 3);
    settle(mk("post reset", 1024, 0, 0, 0, 0, 32'h00000000, -1), 1);
    write(2'd0, 8'd64);
    settle(mk("post reset ch0", 1024, 256, 0, 0, 0, 32'h00000040, 256), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/m_pwm_bank.md
M_PWM_BANK -- requirements
Module: m_pwm_bank

Interface
REQ-001 The block SHALL have parameter CH, default 4: number of PWM channels.
REQ-002 The block SHALL have parameter W, default 8: counter and duty width in bits.
REQ-003 The block SHALL have parameter PW, default 16: prescaler width in bits.
REQ-004 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port presc, input, PW: prescale value; one counter tick every presc+1 clk cycles.
REQ-007 The block SHALL have port mode, input, 1: 0 edge-aligned, 1 center-aligned.
REQ-008 The block SHALL have port wr_en, input, 1: write strobe for a channel's pending duty.
REQ-009 The block SHALL have port wr_ch, input, $clog2(CH): channel to write.
REQ-010 The block SHALL have port wr_duty, input, W: duty value to write.
REQ-011 The block SHALL have port up, input, CH: per-channel pending duty increment request.
REQ-012 The block SHALL have port down, input, CH: per-channel pending duty decrement request.
REQ-013 The block SHALL have port pwm, output, CH: PWM outputs.
REQ-014 The block SHALL have port duty_out, output, CH*W: active duties, channel i at bits [i*W +: W].
REQ-015 The block SHALL have port period_start, output, 1: one-clk pulse at each period boundary.

Function
REQ-016 Prescaler: pcnt SHALL count 0..presc; tick=1 when pcnt==presc, and pcnt SHALL return to 0 on that cycle; presc=0 SHALL give tick every clk.
REQ-017 Edge mode: cnt SHALL increment on each tick and wrap from 2^W-1 to 0; period SHALL be 2^W ticks.
REQ-018 Center mode: cnt SHALL count up to 2^W-1, then down to 0, then up again; direction SHALL reverse on the tick that reaches an end; period SHALL be 2*(2^W-1) ticks.
REQ-019 Boundary SHALL be a tick while cnt==0; period_start SHALL equal boundary, combinationally, for exactly one clk.
REQ-020 mode SHALL be sampled into mode_q only at a boundary; a mid-period mode change SHALL take effect at the next boundary, with cnt=0 and direction up.
REQ-021 Per-channel pending duty pend[i] SHALL change every clk.
REQ-022 pend[i] SHALL take wr_duty when wr_en and wr_ch==i.
REQ-023 Otherwise pend[i] SHALL take pend[i]+1 if up[i]&~down[i], saturating at 2^W-1.
REQ-024 Otherwise pend[i] SHALL take pend[i]-1 if down[i]&~up[i], saturating at 0.
REQ-025 With up[i]&down[i], or with neither asserted, pend[i] SHALL hold.
REQ-026 wr_en with wr_ch>=CH SHALL be ignored.
REQ-027 Active duty act[i] SHALL load pend[i] only at a boundary, giving glitch-free updates; if a write and a boundary fall on the same clk, act[i] SHALL get the old pend[i].
REQ-028 pwm[i] SHALL be 0 when act[i]==0.
REQ-029 pwm[i] SHALL be 1 when act[i]==2^W-1, constant across the whole period (true 100%).
REQ-030 Otherwise pwm[i] SHALL be (cnt < act[i]).
REQ-031 pwm SHALL be registered: one clk latency after cnt/act change.
REQ-032 duty_out SHALL reflect act directly.
REQ-033 Center mode SHALL produce a high pulse symmetric about cnt==0 of width 2*act[i]-1 ticks for 0<act[i]<2^W-1.

Reset
REQ-034 While rst_n=0, pcnt, cnt, pend, act, pwm and mode_q SHALL be 0, direction up, period_start=0, duty_out=0.
REQ-035 Assertion of rst_n mid-period SHALL clear state immediately, without waiting for clk.
REQ-036 After release, the first tick SHALL occur presc+1 clks later, and cnt==0 at that tick SHALL count as a boundary.

Structure
REQ-037 Package m_pwm_pkg SHALL hold the mode encoding constants (MODE_EDGE=0, MODE_CENTER=1) and a saturating inc/dec function usable for any W.
REQ-038 The sub-module m_pwm_timebase SHALL contain prescaler, cnt, direction, mode_q and boundary; it SHALL be instantiated once, with a generate loop for channels.

Verification
REQ-039 W=8, presc=0, edge, wr ch0=64 -> after next boundary pwm[0] high 64 of every 256 clks, duty_out[7:0]=64.
REQ-040 presc=3 -> tick every 4 clks; period_start every 1024 clks.
REQ-041 act=255 -> pwm constant 1 for full period; act=0 -> constant 0.
REQ-042 Center mode, act=10, presc=0 -> period 510 clks, pwm high 19 consecutive clks centred on cnt==0.
REQ-043 Hold up[1] 300 clks from 0 -> pend saturates at 255; up&down together -> no change; wr_en same cycle as up -> wr_duty wins.
REQ-044 Change wr_duty mid-period -> pwm unchanged until period_start; assert rst_n=0 mid-period -> all outputs 0 asynchronously.
